// File: rtl/writeback_regfile_pkg.sv
// Shared processor definitions for the writeback stage and register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package writeback_regfile_pkg;

   // Default widths of the writeback datapath
   localparam int WB_DATA_W = 8;
   localparam int WB_ADDR_W = 3;
   localparam int WB_CNT_W  = 16;

   // Freeze state machine encoding
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   // Writeback source mux: memory data for loads, ALU result otherwise
   function automatic logic [WB_DATA_W-1:0] wb_select(
      input logic                 sel_mem,
      input logic [WB_DATA_W-1:0] alu,
      input logic [WB_DATA_W-1:0] mem
   );
      return sel_mem ? mem : alu;
   endfunction

endpackage

// File: rtl/writeback_regfile_sat_counter.sv
// Saturating event counter: counts enable pulses, sticks at all-ones.
// Latency: count visible one cycle after the enable edge.
// Backpressure: none; an increment at saturation is silently dropped.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic         w_sat;

   assign w_sat = &r_cnt;

   // Increment on enable unless already saturated
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback mux + flop-based register file with bypassed reads, retire/load stats and a done freeze.
// Latency: reads and wb_data are combinational; writes/counters commit on the next rising edge.
// Backpressure: none; once done is seen, writes and counters are frozen until reset.
module writeback_regfile
   import writeback_regfile_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int CNT_W  = WB_CNT_W
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              regwrite_i,
   input  logic              write_data_control_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] q_i,
   input  logic [ADDR_W-1:0] write_addr_i,
   input  logic              memread_i,
   input  logic              done_i,
   input  logic [ADDR_W-1:0] rd_addr_a_i,
   input  logic [ADDR_W-1:0] rd_addr_b_i,
   output logic [DATA_W-1:0] rd_data_a_o,
   output logic [DATA_W-1:0] rd_data_b_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  retired_o,
   output logic [CNT_W-1:0]  loads_o
);

   localparam int NREG = 2 ** ADDR_W;

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [DATA_W-1:0] r_regs [NREG];
   logic [DATA_W-1:0] w_wb_data;
   logic              w_run;
   logic              w_wr_eff;
   logic              w_load_eff;

   // Source select is combinational so the value can also be forwarded upstream
   always_comb begin
      w_wb_data = alu_result_i;
      if (write_data_control_i) begin
         w_wb_data = q_i;
      end
   end

   assign wb_data_o  = w_wb_data;
   assign w_run      = (r_state == ST_RUN);
   assign done_o     = (r_state == ST_HALTED);

   // A write to r0 is dropped, but a load to r0 still counts as a load
   assign w_wr_eff   = regwrite_i && w_run && (write_addr_i != '0);
   assign w_load_eff = regwrite_i && w_run && memread_i;

   // Freeze FSM: leaves RUN on done, returns only through reset
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_RUN && done_i) begin
         w_state_nxt = ST_HALTED;
      end
   end

   // State register; the done edge itself still commits any write in flight
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Register storage in flops so the whole file clears on asynchronous reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_eff) begin
         r_regs[write_addr_i] <= w_wb_data;
      end
   end

   // Port A read with write-through bypass; r0 is hard-wired to zero
   always_comb begin
      rd_data_a_o = r_regs[rd_addr_a_i];
      if (rd_addr_a_i == '0) begin
         rd_data_a_o = '0;
      end else if (w_wr_eff && (rd_addr_a_i == write_addr_i)) begin
         rd_data_a_o = w_wb_data;
      end
   end

   // Port B read, identical to and independent of port A
   always_comb begin
      rd_data_b_o = r_regs[rd_addr_b_i];
      if (rd_addr_b_i == '0) begin
         rd_data_b_o = '0;
      end else if (w_wr_eff && (rd_addr_b_i == write_addr_i)) begin
         rd_data_b_o = w_wb_data;
      end
   end

   sat_counter #(.W(CNT_W)) u_retired_cnt (
      .i_clk   (clk_i),
      .i_rst_n (reset_n_i),
      .i_inc   (w_wr_eff),
      .o_cnt   (retired_o)
   );

   sat_counter #(.W(CNT_W)) u_loads_cnt (
      .i_clk   (clk_i),
      .i_rst_n (reset_n_i),
      .i_inc   (w_load_eff),
      .o_cnt   (loads_o)
   );

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 16;

   logic              clk_i;
   logic              reset_n_i;
   logic              regwrite_i;
   logic              write_data_control_i;
   logic [DATA_W-1:0] alu_result_i;
   logic [DATA_W-1:0] q_i;
   logic [ADDR_W-1:0] write_addr_i;
   logic              memread_i;
   logic              done_i;
   logic [ADDR_W-1:0] rd_addr_a_i;
   logic [ADDR_W-1:0] rd_addr_b_i;
   logic [DATA_W-1:0] rd_data_a_o;
   logic [DATA_W-1:0] rd_data_b_o;
   logic [DATA_W-1:0] wb_data_o;
   logic              done_o;
   logic [CNT_W-1:0]  retired_o;
   logic [CNT_W-1:0]  loads_o;

   writeback_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i                (clk_i),
      .reset_n_i            (reset_n_i),
      .regwrite_i           (regwrite_i),
      .write_data_control_i (write_data_control_i),
      .alu_result_i         (alu_result_i),
      .q_i                  (q_i),
      .write_addr_i         (write_addr_i),
      .memread_i            (memread_i),
      .done_i               (done_i),
      .rd_addr_a_i          (rd_addr_a_i),
      .rd_addr_b_i          (rd_addr_b_i),
      .rd_data_a_o          (rd_data_a_o),
      .rd_data_b_o          (rd_data_b_o),
      .wb_data_o            (wb_data_o),
      .done_o               (done_o),
      .retired_o            (retired_o),
      .loads_o              (loads_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_mis = 0;

   // Scoreboard: expectations queued at drive time, consumed at observation time
   logic [31:0] exp_q [$];
   string       tag_q [$];

   // Bench-side model of counters
   int exp_ret;
   int exp_ld;

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_mis++;
         $error("FAIL scoreboard_empty obs=%h exp=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            n_mis++;
            $error("FAIL %s obs=%h exp=%h", t, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      regwrite_i           = 1'b0;
      write_data_control_i = 1'b0;
      memread_i            = 1'b0;
      done_i               = 1'b0;
      alu_result_i         = '0;
      q_i                  = '0;
      write_addr_i         = '0;
   endtask

   task automatic drive_wr(input logic [ADDR_W-1:0] a, input logic ctl,
                           input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] q,
                           input logic mem, input logic dn);
      regwrite_i           = 1'b1;
      write_addr_i         = a;
      write_data_control_i = ctl;
      alu_result_i         = alu;
      q_i                  = q;
      memread_i            = mem;
      done_i               = dn;
   endtask

   initial begin
      idle();
      rd_addr_a_i = 3'd3;
      rd_addr_b_i = 3'd5;
      reset_n_i   = 1'b0;
      exp_ret     = 0;
      exp_ld      = 0;
      #2;
      // Reset state
      expect_v("rst_done", 32'd0);     check({31'd0, done_o});
      expect_v("rst_retired", 32'd0);  check({16'd0, retired_o});
      expect_v("rst_loads", 32'd0);    check({16'd0, loads_o});
      expect_v("rst_rd_a", 32'd0);     check({24'd0, rd_data_a_o});
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // r3 = 0x5A via ALU path, then read it back next cycle
      tick();
      drive_wr(3'd3, 1'b0, 8'h5A, 8'hEE, 1'b0, 1'b0);
      #1;
      expect_v("wb_alu_sel", 32'h5A);  check({24'd0, wb_data_o});
      tick();
      exp_ret++;
      idle();
      rd_addr_a_i = 3'd3;
      #1;
      expect_v("r3_read_a", 32'h5A);   check({24'd0, rd_data_a_o});
      expect_v("retired_1", exp_ret);  check({16'd0, retired_o});

      // Load r5 from q_i with same-cycle bypass on port B
      drive_wr(3'd5, 1'b1, 8'h99, 8'hC3, 1'b1, 1'b0);
      rd_addr_b_i = 3'd5;
      rd_addr_a_i = 3'd5;
      #1;
      expect_v("wb_mem_sel", 32'hC3);  check({24'd0, wb_data_o});
      expect_v("bypass_b", 32'hC3);    check({24'd0, rd_data_b_o});
      expect_v("bypass_a_same", 32'hC3); check({24'd0, rd_data_a_o});
      tick();
      exp_ret++;
      exp_ld++;
      idle();
      #1;
      expect_v("loads_1", exp_ld);     check({16'd0, loads_o});
      expect_v("r5_stored_b", 32'hC3); check({24'd0, rd_data_b_o});

      // Write to r0 is discarded; a load to r0 counts as a load only
      drive_wr(3'd0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
      rd_addr_a_i = 3'd0;
      rd_addr_b_i = 3'd0;
      #1;
      expect_v("r0_bypass_a", 32'h0);  check({24'd0, rd_data_a_o});
      tick();
      drive_wr(3'd0, 1'b1, 8'h00, 8'hAB, 1'b1, 1'b0);
      tick();
      exp_ld++;
      idle();
      #1;
      expect_v("r0_read_b", 32'h0);    check({24'd0, rd_data_b_o});
      expect_v("r0_retired_same", exp_ret); check({16'd0, retired_o});
      expect_v("r0_load_counted", exp_ld);  check({16'd0, loads_o});

      // Drive retired up to 0xFFFE, then three more writes must saturate
      for (int i = exp_ret; i < 32'hFFFE; i++) begin
         drive_wr(3'd1, 1'b0, DATA_W'(i), 8'h00, 1'b0, 1'b0);
         tick();
         exp_ret++;
      end
      idle();
      rd_addr_a_i = 3'd1;
      #1;
      expect_v("retired_fffe", exp_ret); check({16'd0, retired_o});
      expect_v("r1_last", 32'hFD);       check({24'd0, rd_data_a_o});
      for (int i = 0; i < 3; i++) begin
         drive_wr(3'd1, 1'b0, 8'h40 + 8'(i), 8'h00, 1'b0, 1'b0);
         tick();
      end
      idle();
      #1;
      expect_v("retired_sat", 32'hFFFF); check({16'd0, retired_o});
      expect_v("r1_after_sat", 32'h42);  check({24'd0, rd_data_a_o});

      // Asynchronous reset in the middle of a write
      drive_wr(3'd4, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0);
      rd_addr_a_i = 3'd4;
      rd_addr_b_i = 3'd1;
      #1;
      expect_v("pre_rst_bypass", 32'h77); check({24'd0, rd_data_a_o});
      #2;
      reset_n_i = 1'b0;
      #1;
      expect_v("arst_retired", 32'd0);  check({16'd0, retired_o});
      expect_v("arst_loads", 32'd0);    check({16'd0, loads_o});
      expect_v("arst_done", 32'd0);     check({31'd0, done_o});
      expect_v("arst_r1", 32'd0);       check({24'd0, rd_data_b_o});
      tick();
      expect_v("arst_edge_retired", 32'd0); check({16'd0, retired_o});
      idle();
      #1;
      expect_v("arst_r4_no_commit", 32'd0); check({24'd0, rd_data_a_o});
      @(negedge clk_i);
      reset_n_i = 1'b1;
      exp_ret = 0;
      exp_ld  = 0;

      // First edge after reset release operates normally
      #1;
      drive_wr(3'd6, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0);
      tick();
      exp_ret++;
      idle();
      rd_addr_a_i = 3'd6;
      #1;
      expect_v("post_rst_r6", 32'h33);  check({24'd0, rd_data_a_o});
      expect_v("post_rst_ret", exp_ret); check({16'd0, retired_o});

      // done with a simultaneous write: write commits, then everything freezes
      drive_wr(3'd2, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1);
      tick();
      exp_ret++;
      idle();
      rd_addr_a_i = 3'd2;
      #1;
      expect_v("done_set", 32'd1);      check({31'd0, done_o});
      drive_wr(3'd2, 1'b0, 8'h22, 8'h00, 1'b1, 1'b0);
      #1;
      expect_v("halted_no_bypass", 32'h11); check({24'd0, rd_data_a_o});
      tick();
      idle();
      #1;
      expect_v("halted_r2", 32'h11);    check({24'd0, rd_data_a_o});
      expect_v("halted_retired", exp_ret); check({16'd0, retired_o});
      expect_v("halted_loads", exp_ld);  check({16'd0, loads_o});
      expect_v("done_sticky", 32'd1);   check({31'd0, done_o});

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
